// File: rtl/fetch_unit.sv
// Buffered instruction-fetch stage: owns the PC, reads a combinational instruction
// memory and queues {pc, pc+4, instr} for decode behind a valid/ready handshake.
module fetch_unit #(
  parameter int                    DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = '0,
  parameter int                    FIFO_DEPTH   = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  output logic [DATA_WIDTH-1:0]         imem_addr,
  input  logic [DATA_WIDTH-1:0]         imem_instr,
  input  logic                          redirect_en,
  input  logic [DATA_WIDTH-1:0]         redirect_target,
  output logic                          id_valid,
  input  logic                          id_ready,
  output logic [DATA_WIDTH-1:0]         id_instr,
  output logic [DATA_WIDTH-1:0]         id_pc,
  output logic [DATA_WIDTH-1:0]         id_pc_plus_4,
  output logic [$clog2(FIFO_DEPTH):0]   occupancy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;

  logic [DATA_WIDTH-1:0] pc_mem    [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] pc4_mem   [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] instr_mem [FIFO_DEPTH];

  // Last head value shown to decode; presented while the buffer is empty.
  logic [DATA_WIDTH-1:0] hold_pc_q, hold_pc4_q, hold_instr_q;

  logic                  pop;
  logic                  push;
  logic [DATA_WIDTH-1:0] pc_plus_4;
  logic [DATA_WIDTH-1:0] redirect_pc;

  assign imem_addr   = pc_q;
  assign pc_plus_4   = pc_q + DATA_WIDTH'(4);
  assign redirect_pc = redirect_target & ~DATA_WIDTH'(3);
  assign occupancy   = count_q;
  assign id_valid    = (count_q != '0);

  assign pop  = id_valid & id_ready;
  assign push = !redirect_en & ((count_q < DEPTH_C) | pop);

  always_comb begin
    id_pc        = hold_pc_q;
    id_pc_plus_4 = hold_pc4_q;
    id_instr     = hold_instr_q;
    if (id_valid) begin
      id_pc        = pc_mem[rd_ptr_q];
      id_pc_plus_4 = pc4_mem[rd_ptr_q];
      id_instr     = instr_mem[rd_ptr_q];
    end
  end

  always_comb begin
    pc_d     = pc_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (redirect_en) begin
      // A pop this cycle still completes for decode; the buffer is simply dropped.
      pc_d     = redirect_pc;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        pc_d     = pc_plus_4;
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q         <= RESET_VECTOR;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      hold_pc_q    <= '0;
      hold_pc4_q   <= '0;
      hold_instr_q <= '0;
    end else begin
      pc_q         <= pc_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      hold_pc_q    <= id_pc;
      hold_pc4_q   <= id_pc_plus_4;
      hold_instr_q <= id_instr;
    end
  end

  // Buffer storage carries no reset; entries are only visible once written.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      pc_mem[wr_ptr_q]    <= pc_q;
      pc4_mem[wr_ptr_q]   <= pc_plus_4;
      instr_mem[wr_ptr_q] <= imem_instr;
    end
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Parametrised, buffered instruction-fetch stage; successor to the flat pc_reg/pc_mux/plus-4 fetch path.
- Owns the PC and drives a combinational instruction-memory read port (instr_mem style: address in, instruction out the same cycle).
- Pushes {pc, pc+4, instr} into a small FIFO that decouples fetch from decode via a valid/ready handshake.
- Accepts redirects (branch/jump target) from execute; a redirect flushes all buffered instructions.

Parameters:
- DATA_WIDTH, 32, width of PC, addresses and instruction words.
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset; must be 4-byte aligned.
- FIFO_DEPTH, 2, number of fetch-buffer entries; power of two, at least 2.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- imem_addr  out  DATA_WIDTH  instruction-memory address; equals the PC register, combinational.
- imem_instr  in  DATA_WIDTH  instruction read at imem_addr, same cycle.
- redirect_en  in  1  load the PC from redirect_target and flush the FIFO.
- redirect_target  in  DATA_WIDTH  new PC; bits [1:0] are forced to 0.
- id_valid  out  1  FIFO head holds a valid instruction.
- id_ready  in  1  decode accepts the head this cycle.
- id_instr  out  DATA_WIDTH  head instruction.
- id_pc  out  DATA_WIDTH  head PC.
- id_pc_plus_4  out  DATA_WIDTH  head PC + 4, modulo 2^DATA_WIDTH.
- occupancy  out  $clog2(FIFO_DEPTH)+1  current number of valid FIFO entries.

Behaviour:
- Reset (rst=1 at a clk edge):
  - pc <= RESET_VECTOR; FIFO emptied (pointers 0, count 0).
  - id_valid=0, occupancy=0. id_instr, id_pc and id_pc_plus_4 are 0 after reset.
  - Reset overrides redirect_en and any handshake, including mid-stream.
- Definitions:
  - pop = id_valid & id_ready.
  - push = !redirect_en & (count < FIFO_DEPTH | pop).
  - A push enqueues {pc, pc+4, imem_instr} and updates pc <= pc + 4 (wraps at 2^DATA_WIDTH).
  - With no push and no redirect, pc holds.
- Redirect (redirect_en=1, rst=0):
  - pc <= {redirect_target[DATA_WIDTH-1:2], 2'b00}.
  - FIFO cleared: count 0, pointers reset.
  - No push that cycle; the instruction at the old pc is discarded.
  - A pop in the same cycle is still a completed handshake from decode's point of view. Decode/execute is responsible for killing it.
  - Consecutive redirects: each one wins; the last target is the one fetched.
- Latency:
  - Push in cycle N makes the entry visible at the head in cycle N+1 if the FIFO was empty.
  - Redirect in cycle N: target fetched and pushed in N+1; id_valid=1 with id_pc=target in N+2.
  - First instruction after reset release: id_valid=1 in the second cycle after rst deasserts.
- Head outputs:
  - id_instr, id_pc and id_pc_plus_4 come from the FIFO storage at the read pointer.
  - id_valid = (count != 0).
  - When id_valid=0, head outputs hold their last value; they are don't-care to decode.
- Full:
  - count==FIFO_DEPTH with no pop: no push, pc holds, imem_addr stable.
  - Full with pop: push and pop in the same cycle, count unchanged.
- Empty:
  - id_valid=0; a pop is impossible.
  - A push makes count=1 next cycle.
- Pointers wrap modulo FIFO_DEPTH.
- Count update: count_next = count + push - pop, except 0 on redirect or reset.
- Stream ordering: entries leave in push order, and id_pc advances by 4 per popped entry between redirects.
- id_pc_plus_4 is the value stored at push time, not recomputed.

Test Plan:
- Reset with RESET_VECTOR=0x100, imem returns addr^0xA5A5_0000, id_ready=1: id_pc sequence 0x100, 0x104, 0x108… with id_valid first high 2 cycles after rst falls; id_instr matches pattern.
- Backpressure, FIFO_DEPTH=2, id_ready=0 for 6 cycles: occupancy reaches 2, imem_addr freezes at 0x108. Then id_ready=1: entries 0x100, 0x104, 0x108 delivered in order, none lost or duplicated.
- Redirect to 0x2003 while full and id_ready=1: next cycle occupancy=0 and imem_addr=0x2000; two cycles later id_valid=1, id_pc=0x2000, id_pc_plus_4=0x2004.
- Back-to-back redirects to 0x400 then 0x800: only 0x800 stream delivered; no 0x400 entry ever appears at the head.
- Wrap: redirect to 0xFFFF_FFFC: id_pc=0xFFFF_FFFC with id_pc_plus_4=0x0000_0000, next id_pc=0x0000_0000.
- rst asserted mid-stream with occupancy=2 and redirect_en=1 in the same cycle: next cycle id_valid=0, occupancy=0, imem_addr=RESET_VECTOR.
